// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite slave backed by a byte-writable word SRAM with wait states
// A transfer is checked for legality when accepted; illegal ones get the two-cycle ERROR response.
module ahb_lite_sram_slave #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);
   localparam int         DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                state, state_nxt;
   logic [3:0]            wait_cnt, wait_cnt_nxt;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [1:0]            lane_addr;
   logic [1:0]            size_reg;
   logic                  write_reg;
   logic [31:0]           mem [DEPTH];

   logic                  accept_window;
   logic                  accept;
   logic                  legal;
   logic [3:0]            lane_en;
   logic                  unused_sideband;

   assign unused_sideband = ^{HBURST, HPROT, HMASTLOCK};

   // New address phases are only taken while this slave is not stalling the bus.
   assign accept_window = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
   assign accept        = accept_window && HSEL && HREADY && HTRANS[1];

   always_comb begin
      legal = 1'b1;
      if (HSIZE > 3'd2)
         legal = 1'b0;
      if ((HSIZE == 3'd1) && HADDR[0])
         legal = 1'b0;
      if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
         legal = 1'b0;
      if ((HADDR >> (ADDR_WIDTH + 2)) != 32'd0)
         legal = 1'b0;
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         ST_WAIT: begin
            if (wait_cnt == WS_LAST) begin
               state_nxt    = ST_DATA;
               wait_cnt_nxt = 4'd0;
            end else begin
               wait_cnt_nxt = wait_cnt + 4'd1;
            end
         end
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_IDLE;
      endcase
      if (accept) begin
         wait_cnt_nxt = 4'd0;
         if (!legal)
            state_nxt = ST_ERR1;
         else if (WAIT_STATES > 0)
            state_nxt = ST_WAIT;
         else
            state_nxt = ST_DATA;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= ST_IDLE;
         wait_cnt  <= 4'd0;
         word_addr <= '0;
         lane_addr <= 2'b00;
         size_reg  <= 2'b00;
         write_reg <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (accept) begin
            word_addr <= HADDR[ADDR_WIDTH+1:2];
            lane_addr <= HADDR[1:0];
            size_reg  <= HSIZE[1:0];
            write_reg <= HWRITE;
         end
      end
   end

   // Little-endian lanes; a legal halfword always starts on an even lane.
   always_comb begin
      lane_en = 4'b0000;
      case (size_reg)
         2'd0:    lane_en[lane_addr] = 1'b1;
         2'd1:    lane_en = lane_addr[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESET && (state == ST_DATA) && write_reg) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i])
               mem[word_addr][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

   assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
   assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
   assign HRDATA    = ((state == ST_DATA) && !write_reg) ? mem[word_addr] : 32'd0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - randomized self-checking bench for ahb_lite_sram_slave
// Two instances (zero and two wait states) are driven by a pipelined master and checked against a word-array model.
module tb_ahb_lite_sram_slave;
   localparam int AW  = 8;
   localparam int NW  = 16;
   localparam int WS0 = 0;
   localparam int WS1 = 2;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic [31:0] addr;
      logic [2:0]  size;
      logic        write;
      logic [31:0] wdata;
   } xfer_t;

   logic        clk = 1'b0;
   logic        hreset    [2];
   logic        hsel      [2];
   logic [31:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [2:0]  hburst    [2];
   logic [3:0]  hprot     [2];
   logic        hmastlock [2];
   logic [31:0] hwdata    [2];
   logic [31:0] hrdata    [2];
   logic        hreadyout [2];
   logic        hresp     [2];

   xfer_t       xq [$];
   logic [31:0] model [2][NW];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   ahb_lite_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS0)) u_ws0 (
      .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
      .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]),
      .HMASTLOCK(hmastlock[0]), .HREADY(hreadyout[0]), .HWDATA(hwdata[0]),
      .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
   );

   ahb_lite_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS1)) u_ws2 (
      .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
      .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]),
      .HMASTLOCK(hmastlock[1]), .HREADY(hreadyout[1]), .HWDATA(hwdata[1]),
      .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_accept(input xfer_t x);
      return x.sel && x.trans[1];
   endfunction

   function automatic bit is_legal(input xfer_t x);
      if (x.size > 3'd2) return 1'b0;
      if ((x.addr % (32'd1 << x.size)) != 32'd0) return 1'b0;
      if (x.addr >= (32'd4 << AW)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int widx(input xfer_t x);
      return int'((x.addr >> 2) % NW);
   endfunction

   function automatic void model_write(input int k, input xfer_t x);
      logic [31:0] w;
      int          lane;
      w = model[k][widx(x)];
      for (int b = 0; b < (1 << x.size); b++) begin
         lane = int'(x.addr % 4) + b;
         w[lane*8 +: 8] = x.wdata[lane*8 +: 8];
      end
      model[k][widx(x)] = w;
   endfunction

   function automatic xfer_t mk(input logic wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      xfer_t x;
      x.sel = 1'b1; x.trans = 2'b10; x.addr = a; x.size = s; x.write = wr; x.wdata = d;
      return x;
   endfunction

   function automatic xfer_t idle_x();
      xfer_t x;
      x.sel = 1'b0; x.trans = 2'b00; x.addr = 32'd0; x.size = 3'd0; x.write = 1'b0; x.wdata = 32'd0;
      return x;
   endfunction

   task automatic drive_ap(input int k, input xfer_t x);
      hsel[k]      = x.sel;
      htrans[k]    = x.trans;
      haddr[k]     = x.addr;
      hsize[k]     = x.size;
      hwrite[k]    = x.write;
      hburst[k]    = 3'($urandom);
      hprot[k]     = 4'($urandom);
      hmastlock[k] = 1'($urandom);
   endtask

   task automatic summary();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
   endtask

   // Pipelined master: the address phase advances only when the slave completes the data phase.
   task automatic run_seq(input int k, input int ws);
      xfer_t ap, dp;
      bit    dp_v;
      int    dp_cycles;
      logic  rdy;
      @(posedge clk); #1;
      dp_v = 1'b0;
      dp_cycles = 0;
      dp = idle_x();
      ap = (xq.size() > 0) ? xq.pop_front() : idle_x();
      drive_ap(k, ap);
      hwdata[k] = $urandom;
      while (dp_v || is_accept(ap) || xq.size() > 0) begin
         @(negedge clk);
         rdy = hreadyout[k];
         if (dp_v) begin
            check_eq("hresp", 32'(hresp[k]), is_legal(dp) ? 32'd0 : 32'd1);
            if (rdy) begin
               check_eq("wait_cycles", dp_cycles, is_legal(dp) ? ws : 1);
               check_eq("hrdata", hrdata[k], (is_legal(dp) && !dp.write) ? model[k][widx(dp)] : 32'd0);
               if (is_legal(dp) && dp.write)
                  model_write(k, dp);
            end else begin
               check_eq("hrdata_wait", hrdata[k], 32'd0);
               dp_cycles++;
               if (dp_cycles > 20) begin
                  check_eq("stuck_wait", 32'(dp_cycles), 32'(ws));
                  summary();
                  $fatal(1, "bench aborted: data phase never completed");
               end
            end
         end else begin
            check_eq("idle_ready_resp", {30'd0, hreadyout[k], hresp[k]}, 32'd2);
            check_eq("idle_rdata", hrdata[k], 32'd0);
         end
         @(posedge clk); #1;
         if (rdy) begin
            dp_v = is_accept(ap);
            dp = ap;
            dp_cycles = 0;
            ap = (xq.size() > 0) ? xq.pop_front() : idle_x();
            drive_ap(k, ap);
            hwdata[k] = (dp_v && dp.write) ? dp.wdata : $urandom;
         end
      end
   endtask

   task automatic push_random(input int n);
      for (int i = 0; i < n; i++) begin
         xfer_t x;
         int    r;
         r = $urandom_range(0, 99);
         x.sel   = 1'b1;
         x.trans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
         x.write = 1'($urandom);
         x.wdata = $urandom;
         x.size  = 3'($urandom_range(0, 2));
         x.addr  = 32'($urandom_range(0, NW - 1)) * 32'd4;
         if ($urandom_range(0, 9) < 4)
            x.addr = x.addr + 32'($urandom_range(0, 3));
         if (r < 4) begin
            x.sel   = 1'b0;
            x.trans = 2'($urandom);
            x.write = 1'b1;
         end else if (r < 10) begin
            x.trans = 2'($urandom_range(0, 1));
            x.write = 1'b1;
         end else if (r < 15) begin
            x.size = 3'($urandom_range(3, 7));
         end else if (r < 20) begin
            x.addr = x.addr | (32'd1 << $urandom_range(10, 31));
         end
         xq.push_back(x);
      end
   endtask

   initial begin
      xfer_t x;
      for (int k = 0; k < 2; k++) begin
         hreset[k] = 1'b1;
         drive_ap(k, idle_x());
         hwdata[k] = 32'd0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check_eq("reset_hreadyout", 32'(hreadyout[k]), 32'd1);
         check_eq("reset_hresp", 32'(hresp[k]), 32'd0);
         check_eq("reset_hrdata", hrdata[k], 32'd0);
      end
      @(posedge clk); #1;
      hreset[0] = 1'b0;
      hreset[1] = 1'b0;

      for (int k = 0; k < 2; k++) begin
         for (int w = 0; w < NW; w++)
            xq.push_back(mk(1'b1, 32'(w * 4), 3'd2, $urandom));
         run_seq(k, (k == 0) ? WS0 : WS1);
      end

      xq.push_back(mk(1'b1, 32'h0, 3'd2, 32'h0000AABB));
      xq.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
      xq.push_back(mk(1'b1, 32'h4, 3'd2, 32'h11223344));
      xq.push_back(mk(1'b1, 32'h6, 3'd0, 32'h55CC5555));
      xq.push_back(mk(1'b0, 32'h4, 3'd2, 32'h0));
      run_seq(0, WS0);
      check_eq("model_word0", model[0][0], 32'h0000AABB);
      check_eq("model_byte_merge", model[0][1], 32'h11CC3344);

      xq.push_back(mk(1'b0, 32'h8, 3'd2, 32'h0));
      xq.push_back(mk(1'b0, 32'h8, 3'd2, 32'h0));
      xq.push_back(mk(1'b0, 32'h2, 3'd2, 32'h0));
      xq.push_back(mk(1'b0, 32'h400, 3'd2, 32'h0));
      xq.push_back(mk(1'b1, 32'h400, 3'd2, 32'hBAD0BAD0));
      xq.push_back(mk(1'b1, 32'h10, 3'd3, 32'hBAD1BAD1));
      xq.push_back(mk(1'b1, 32'h11, 3'd1, 32'hBAD2BAD2));
      xq.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
      xq.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
      run_seq(1, WS1);

      x = mk(1'b1, 32'hC, 3'd2, ~model[1][3]);
      drive_ap(1, x);
      @(posedge clk); #1;
      drive_ap(1, idle_x());
      hwdata[1] = x.wdata;
      @(negedge clk);
      check_eq("rst_write_in_wait", 32'(hreadyout[1]), 32'd0);
      @(posedge clk); #1;
      hreset[1] = 1'b1;
      @(posedge clk); #1;
      hreset[1] = 1'b0;
      @(negedge clk);
      check_eq("rst_abort_ready_resp", {30'd0, hreadyout[1], hresp[1]}, 32'd2);
      check_eq("rst_abort_rdata", hrdata[1], 32'd0);
      xq.push_back(mk(1'b0, 32'hC, 3'd2, 32'h0));
      run_seq(1, WS1);

      push_random(300);
      run_seq(0, WS0);
      push_random(300);
      run_seq(1, WS1);

      summary();
      $finish;
   end
endmodule
